instr_fetch_seq: RTL

- Upstream instruction sequencer for the simple processor (proc).
- Reads program words from a synchronous ROM and drives the processor's DIN and Run.
- Waits for Done; advances the PC by 1, or by 2 for MVI, because MVI's immediate is the next ROM word.
- Provides halt-at-address, instruction count and a watchdog error.

---
 rtl/instr_fetch_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch_seq.sv
// -----------------------------------------------------------------------------
// instr_fetch_seq
//
// Upstream instruction sequencer for the simple processor (proc). Reads program
// words from a synchronous (registered-read) ROM, presents each instruction on
// DIN with a one-cycle Run pulse and waits for the processor's Done. The PC
// advances by 1, or by 2 after an MVI because the immediate is the next ROM
// word. Also provides halt-at-address, a saturating instruction count and a
// watchdog that traps into a sticky error state.
//
// Build option:
//   STEP_MODE_EN - when defined, adds input Step; FETCH then holds until a
//                  cycle with Step=1, giving one instruction per Step pulse.
//
// Ports:
//   Clock      in   system clock, rising edge
//   Resetn     in   asynchronous, active-low reset
//   Start      in   one-cycle pulse; begins execution from address 0
//   Stop_addr  in   address of the last instruction to execute
//   Mem_addr   out  ROM address (combinational from state/PC)
//   Mem_q      in   ROM data, valid one cycle after Mem_addr
//   DIN        out  instruction/immediate word to proc
//   Run        out  one-cycle pulse per instruction
//   Done       in   proc completion (last step of the instruction)
//   Step       in   single-step advance (STEP_MODE_EN builds only)
//   Busy       out  high in FETCH, ISSUE and WAIT
//   Halted     out  high in HALT
//   Error      out  high in ERR (sticky until Start or reset)
//   Instr_cnt  out  completed instructions, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module instr_fetch_seq #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Stop_addr,
    output logic [ADDR_W-1:0] Mem_addr,
    input  logic [DATA_W-1:0] Mem_q,
    output logic [DATA_W-1:0] DIN,
    output logic              Run,
    input  logic              Done,
`ifdef STEP_MODE_EN
    input  logic              Step,
`endif
    output logic              Busy,
    output logic              Halted,
    output logic              Error,
    output logic [15:0]       Instr_cnt
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);
    localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PC_TWO   = ADDR_W'(2);
    localparam logic [2:0]        OP_MVI   = 3'd1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_HALT  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [2:0]        opcode_reg;
    logic [TMO_W-1:0]  tmo_reg;
    logic [15:0]       cnt_reg;

    logic [ADDR_W-1:0] pc_plus1;
    logic              in_exec;

    // Natural ADDR_W-bit overflow gives the modulo-2^ADDR_W wrap.
    assign pc_plus1 = pc_reg + PC_ONE;

    // During ISSUE and WAIT the ROM is already addressed at PC+1 so that the
    // MVI immediate sits on DIN during the processor's second step.
    assign in_exec  = (state_reg == S_ISSUE) || (state_reg == S_WAIT);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_reg  <= S_IDLE;
            pc_reg     <= '0;
            opcode_reg <= '0;
            tmo_reg    <= '0;
            cnt_reg    <= '0;
        end else begin
            case (state_reg)
                S_IDLE, S_HALT, S_ERR: begin
                    if (Start) begin
                        state_reg <= S_FETCH;
                        pc_reg    <= '0;
                        cnt_reg   <= '0;
                    end
                end
                S_FETCH: begin
`ifdef STEP_MODE_EN
                    if (Step) begin
                        state_reg <= S_ISSUE;
                    end
`else
                    state_reg <= S_ISSUE;
`endif
                end
                S_ISSUE: begin
                    // Done is ignored here: proc cannot finish in T0.
                    opcode_reg <= Mem_q[8:6];
                    tmo_reg    <= '0;
                    state_reg  <= S_WAIT;
                end
                S_WAIT: begin
                    // Done takes priority over a simultaneous timeout expiry.
                    if (Done) begin
                        if (cnt_reg != 16'hFFFF) begin
                            cnt_reg <= cnt_reg + 16'd1;
                        end
                        if (pc_reg == Stop_addr) begin
                            state_reg <= S_HALT;
                        end else begin
                            pc_reg    <= (opcode_reg == OP_MVI) ? (pc_reg + PC_TWO) : pc_plus1;
                            state_reg <= S_FETCH;
                        end
                    end else begin
                        tmo_reg <= tmo_reg + TMO_ONE;
                        if (tmo_reg == TMO_LAST) begin
                            state_reg <= S_ERR;
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are pure decodes of the registered state and PC.
    assign Mem_addr  = in_exec ? pc_plus1 : pc_reg;
    assign DIN       = in_exec ? Mem_q : '0;
    assign Run       = (state_reg == S_ISSUE);
    assign Busy      = (state_reg == S_FETCH) || in_exec;
    assign Halted    = (state_reg == S_HALT);
    assign Error     = (state_reg == S_ERR);
    assign Instr_cnt = cnt_reg;

endmodule
